wbu: RTL and testbench
======================

# wbu

Writeback unit for the single-issue RV32 NPC core. Accepts one retiring instruction at a time from the execute/memory side over a valid/ready handshake. For loads it waits for the data-memory read response and performs byte/halfword extraction with sign/zero extension. It then drives the register file write port with a one-cycle write strobe and a commit pulse, and exposes the pending destination register for decode-stage hazard stalls.

## Interface
- `WIDTH`, default 32: datapath width. Load extraction is defined for 32 only.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a retiring instruction.
- `in_ready`  out  1  wbu can accept this cycle.
- `in_pc`  in  WIDTH  PC of the instruction.
- `in_rd_addr`  in  5  destination register.
- `in_rd_wen`  in  1  instruction writes rd.
- `in_sel`  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 CSR.
- `in_alu_result`  in  WIDTH  ALU result.
- `in_csr_rdata`  in  WIDTH  CSR old value.
- `in_load_funct3`  in  3  load type.
- `in_addr_low`  in  2  low bits of the load address.
- `mem_rvalid`  in  1  load data response valid.
- `mem_rready`  out  1  wbu accepts a load response.
- `mem_rdata`  in  WIDTH  raw aligned memory word.
- `rf_wen`  out  1  register file write enable.
- `rf_rd_addr`  out  5  register file write address.
- `rf_rd_data`  out  WIDTH  register file write data.
- `commit_valid`  out  1  one-cycle retire pulse.
- `commit_pc`  out  WIDTH  PC of the retired instruction.
- `pending_valid`  out  1  a captured instruction will write a nonzero rd.
- `pending_rd`  out  5  that rd.

## Operation
- FSM states:
  - IDLE: waiting for an instruction.
  - WAIT_MEM: waiting for load data.
  - WRITE: writing back and committing.
- Handshake: `in_ready` = (state==IDLE) | (state==WRITE). A transfer occurs when `in_valid & in_ready`. Fields are captured into internal registers.
- Transitions:
  - On accept: `in_sel`==01 goes to WAIT_MEM; any other `in_sel` goes to WRITE.
  - WRITE with no accept goes to IDLE.
  - WAIT_MEM with `mem_rvalid` goes to WRITE.
- `mem_rready` = (state==WAIT_MEM). `mem_rvalid` outside WAIT_MEM is ignored.
- Result selection at capture:
  - ALU selects `in_alu_result`.
  - PC+4 selects `in_pc`+4, modulo 2^WIDTH.
  - CSR selects `in_csr_rdata`.
  - LOAD takes the extracted `mem_rdata` at response.
- Load extraction:
  - Byte lane = `in_addr_low`. Half lane = `in_addr_low[1]` (bit 0 ignored).
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - 010, and any other code: full word.
- Write gating: `rf_wen` is asserted only if the captured wen is 1 and the captured rd != 0. `rf_rd_addr`/`rf_rd_data` still show the captured values when gated.
- `commit_valid` pulses for every instruction, including no-write ones. `commit_pc` is the captured PC.
- `pending_valid` is high in WAIT_MEM and WRITE when the captured wen=1 and rd!=0. `pending_rd` is the captured rd, or 0 when not pending.

## Timing
- `rf_wen`, `rf_rd_addr`, `rf_rd_data`, `commit_valid` and `commit_pc` are registered. They are valid exactly while state==WRITE (one cycle per instruction).
- Non-load instruction: accept at edge T, outputs valid in cycle T..T+1. The register file updates at edge T+1.
- Load: accept at edge T. If the response arrives at edge T+k (k≥1), WRITE occupies cycle T+k..T+k+1.
- Back-to-back non-loads with `in_valid` held: one instruction per cycle. An accept in WRITE overwrites the captured fields on the same edge that ends the current write.
- The upstream must hold `in_*` stable while `in_valid & ~in_ready`.
- Reset (async, any state, including mid-WAIT_MEM) forces:
  - state IDLE;
  - all outputs 0 except `in_ready`=1;
  - the in-flight instruction is dropped with no write and no commit.
  - A response arriving after reset is ignored.

## Test plan
- ALU op, rd=5, result 0xDEADBEEF, pc=0x80000000:
  - `rf_wen`=1, addr 5, data 0xDEADBEEF for exactly 1 cycle.
  - `commit_pc`=0x80000000.
  - `in_ready` stays high.
- LB, addr_low=3, `mem_rdata`=0x80FF7F01, response 3 cycles after accept:
  - `mem_rready` high for 3 cycles, `in_ready` low.
  - Then `rf_rd_data`=0xFFFFFF80.
  - LBU in the same setup gives 0x00000080.
  - LH with addr_low=2 gives 0xFFFF80FF; LHU with addr_low=0 gives 0x00007F01.
- JAL-style op, `in_sel`=10, pc=0xFFFFFFFC: data 0x00000000 (wrap).
  - Same op with rd=0: `rf_wen`=0, `commit_valid`=1.
- Three back-to-back ALU ops to rd 1, 2, 3:
  - three consecutive `rf_wen` cycles;
  - `pending_rd` shows 1, 2, 3 in sequence.
- Reset asserted mid-WAIT_MEM (rd=7), then `mem_rvalid` pulsed after release:
  - no `rf_wen`, no `commit_valid`, `pending_valid`=0;
  - the next instruction is accepted normally.

Source files
------------

// File: rtl/wbu.sv
// ---------------------------------------------------------------------------
// wbu - writeback unit for the single-issue RV32 NPC core.
//
// Takes one retiring instruction at a time over a valid/ready handshake.
// Loads wait for the data-memory response, then the lane is extracted with
// sign/zero extension. Every instruction produces a one-cycle WRITE phase
// that drives the register file write port and a commit pulse. The
// destination register is exposed while the instruction is in flight so
// decode can stall on hazards.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   retire handshake from execute/memory
//   in_pc, in_rd_addr, in_rd_wen, in_sel, in_alu_result, in_csr_rdata,
//   in_load_funct3, in_addr_low                  retiring instruction fields
//   mem_rvalid/mem_rready/mem_rdata              load data response
//   rf_wen, rf_rd_addr, rf_rd_data               register file write port
//   commit_valid, commit_pc                      retire pulse
//   pending_valid, pending_rd                    in-flight destination
// ---------------------------------------------------------------------------
module wbu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_rd_wen,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic [WIDTH-1:0] in_csr_rdata,
  input  logic [2:0]       in_load_funct3,
  input  logic [1:0]       in_addr_low,
  input  logic             mem_rvalid,
  output logic             mem_rready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [WIDTH-1:0] rf_rd_data,
  output logic             commit_valid,
  output logic [WIDTH-1:0] commit_pc,
  output logic             pending_valid,
  output logic [4:0]       pending_rd
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_CSR  = 2'b11;

  // Non-load result source selection.
  function automatic logic [WIDTH-1:0] sel_result(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] alu,
    input logic [WIDTH-1:0] pc,
    input logic [WIDTH-1:0] csr
  );
    logic [WIDTH-1:0] res;
    case (sel)
      SEL_ALU: res = alu;
      SEL_PC4: res = pc + WIDTH'(32'd4);  // wraps modulo 2^WIDTH
      SEL_CSR: res = csr;
      default: res = alu;
    endcase
    return res;
  endfunction

  // Load lane extraction; halfword lane uses only addr_low[1].
  function automatic logic [WIDTH-1:0] load_extract(
    input logic [WIDTH-1:0] word,
    input logic [2:0]       funct3,
    input logic [1:0]       lo
  );
    logic [WIDTH-1:0] bsh;
    logic [WIDTH-1:0] hsh;
    logic [WIDTH-1:0] res;
    bsh = word >> {lo, 3'b000};
    hsh = word >> {lo[1], 4'b0000};
    case (funct3)
      3'b000:  res = {{(WIDTH-8){bsh[7]}}, bsh[7:0]};
      3'b001:  res = {{(WIDTH-16){hsh[15]}}, hsh[15:0]};
      3'b100:  res = {{(WIDTH-8){1'b0}}, bsh[7:0]};
      3'b101:  res = {{(WIDTH-16){1'b0}}, hsh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [4:0]       rd_q, rd_d;
  logic             wen_q, wen_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lo_q, lo_d;

  logic             rf_wen_q, rf_wen_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;
  logic             commit_q, commit_d;
  logic [WIDTH-1:0] commit_pc_q, commit_pc_d;
  logic             pend_v_q, pend_v_d;
  logic [4:0]       pend_rd_q, pend_rd_d;

  logic accept_s;
  logic cap_writes_s;
  logic in_writes_s;

  assign in_ready     = (state_q == IDLE) | (state_q == WRITE);
  assign mem_rready   = (state_q == WAIT_MEM);
  assign accept_s     = in_valid & in_ready;
  assign cap_writes_s = wen_q & (rd_q != 5'd0);
  assign in_writes_s  = in_rd_wen & (in_rd_addr != 5'd0);

  // Next state, captured fields and next values of the registered outputs.
  // Outputs are zero unless the next state is WRITE.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    funct3_d    = funct3_q;
    lo_d        = lo_q;
    rf_wen_d    = 1'b0;
    rf_addr_d   = 5'd0;
    rf_data_d   = '0;
    commit_d    = 1'b0;
    commit_pc_d = '0;
    pend_v_d    = 1'b0;
    pend_rd_d   = 5'd0;
    case (state_q)
      IDLE, WRITE: begin
        if (accept_s) begin
          pc_d      = in_pc;
          rd_d      = in_rd_addr;
          wen_d     = in_rd_wen;
          funct3_d  = in_load_funct3;
          lo_d      = in_addr_low;
          pend_v_d  = in_writes_s;
          pend_rd_d = in_writes_s ? in_rd_addr : 5'd0;
          if (in_sel == SEL_LOAD) begin
            state_d = WAIT_MEM;
          end else begin
            state_d     = WRITE;
            rf_wen_d    = in_writes_s;
            rf_addr_d   = in_rd_addr;
            rf_data_d   = sel_result(in_sel, in_alu_result, in_pc, in_csr_rdata);
            commit_d    = 1'b1;
            commit_pc_d = in_pc;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        pend_v_d  = cap_writes_s;
        pend_rd_d = cap_writes_s ? rd_q : 5'd0;
        if (mem_rvalid) begin
          state_d     = WRITE;
          rf_wen_d    = cap_writes_s;
          rf_addr_d   = rd_q;
          rf_data_d   = load_extract(mem_rdata, funct3_q, lo_q);
          commit_d    = 1'b1;
          commit_pc_d = pc_q;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured instruction and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rd_q        <= 5'd0;
      wen_q       <= 1'b0;
      funct3_q    <= 3'd0;
      lo_q        <= 2'd0;
      rf_wen_q    <= 1'b0;
      rf_addr_q   <= 5'd0;
      rf_data_q   <= '0;
      commit_q    <= 1'b0;
      commit_pc_q <= '0;
      pend_v_q    <= 1'b0;
      pend_rd_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      funct3_q    <= funct3_d;
      lo_q        <= lo_d;
      rf_wen_q    <= rf_wen_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      commit_q    <= commit_d;
      commit_pc_q <= commit_pc_d;
      pend_v_q    <= pend_v_d;
      pend_rd_q   <= pend_rd_d;
    end
  end

  assign rf_wen        = rf_wen_q;
  assign rf_rd_addr    = rf_addr_q;
  assign rf_rd_data    = rf_data_q;
  assign commit_valid  = commit_q;
  assign commit_pc     = commit_pc_q;
  assign pending_valid = pend_v_q;
  assign pending_rd    = pend_rd_q;

endmodule

// File: tb/tb_wbu.sv
// ---------------------------------------------------------------------------
// tb_wbu - directed self-checking bench for wbu.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen;
  logic [1:0]  in_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_csr_rdata;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_addr_low;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        pending_valid;
  logic [4:0]  pending_rd;

  int checks;
  int failures;

  wbu #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rd_addr     (in_rd_addr),
    .in_rd_wen      (in_rd_wen),
    .in_sel         (in_sel),
    .in_alu_result  (in_alu_result),
    .in_csr_rdata   (in_csr_rdata),
    .in_load_funct3 (in_load_funct3),
    .in_addr_low    (in_addr_low),
    .mem_rvalid     (mem_rvalid),
    .mem_rready     (mem_rready),
    .mem_rdata      (mem_rdata),
    .rf_wen         (rf_wen),
    .rf_rd_addr     (rf_rd_addr),
    .rf_rd_data     (rf_rd_data),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .pending_valid  (pending_valid),
    .pending_rd     (pending_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                       input logic [31:0] pc, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_sel        = sel;
    in_rd_addr    = rd;
    in_rd_wen     = wen;
    in_pc         = pc;
    in_alu_result = alu;
  endtask

  // Load with response arriving 3 edges after the accept edge.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] exp);
    drive(2'b01, 5'd9, 1'b1, 32'h0000_1000, 32'h0);
    in_load_funct3 = f3;
    in_addr_low    = lo;
    mem_rdata      = 32'h80FF_7F01;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_mem_rready"}, {31'd0, mem_rready}, 32'd1);
      check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      check_eq({tag, "_no_wen"}, {31'd0, rf_wen}, 32'd0);
      if (i == 2) mem_rvalid = 1'b1;
      tick();
    end
    mem_rvalid = 1'b0;
    check_eq({tag, "_wen"}, {31'd0, rf_wen}, 32'd1);
    check_eq({tag, "_data"}, rf_rd_data, exp);
    check_eq({tag, "_addr"}, {27'd0, rf_rd_addr}, 32'd9);
    check_eq({tag, "_commit_pc"}, commit_pc, 32'h0000_1000);
    tick();
    check_eq({tag, "_wen_off"}, {31'd0, rf_wen}, 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_pc          = 32'd0;
    in_rd_addr     = 5'd0;
    in_rd_wen      = 1'b0;
    in_sel         = 2'b00;
    in_alu_result  = 32'd0;
    in_csr_rdata   = 32'd0;
    in_load_funct3 = 3'd0;
    in_addr_low    = 2'd0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'd0;
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mem_rready", {31'd0, mem_rready}, 32'd0);
    check_eq("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check_eq("rst_commit", {31'd0, commit_valid}, 32'd0);
    check_eq("rst_pending", {31'd0, pending_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU op
    drive(2'b00, 5'd5, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
    check_eq("alu_in_ready_pre", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("alu_wen", {31'd0, rf_wen}, 32'd1);
    check_eq("alu_addr", {27'd0, rf_rd_addr}, 32'd5);
    check_eq("alu_data", rf_rd_data, 32'hDEAD_BEEF);
    check_eq("alu_commit", {31'd0, commit_valid}, 32'd1);
    check_eq("alu_commit_pc", commit_pc, 32'h8000_0000);
    check_eq("alu_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("alu_pending_rd", {27'd0, pending_rd}, 32'd5);
    tick();
    check_eq("alu_wen_off", {31'd0, rf_wen}, 32'd0);
    check_eq("alu_commit_off", {31'd0, commit_valid}, 32'd0);
    check_eq("alu_pending_off", {31'd0, pending_valid}, 32'd0);

    // Loads
    do_load("lb", 3'b000, 2'd3, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 2'd3, 32'h0000_0080);
    do_load("lh", 3'b001, 2'd2, 32'hFFFF_80FF);
    do_load("lh_lo3", 3'b001, 2'd3, 32'hFFFF_80FF);
    do_load("lhu", 3'b101, 2'd0, 32'h0000_7F01);
    do_load("lw", 3'b010, 2'd1, 32'h80FF_7F01);
    do_load("lb_lo1", 3'b000, 2'd1, 32'h0000_007F);

    // PC+4 wrap
    drive(2'b10, 5'd1, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111);
    tick();
    in_valid = 1'b0;
    check_eq("jal_wen", {31'd0, rf_wen}, 32'd1);
    check_eq("jal_data", rf_rd_data, 32'h0000_0000);
    tick();
    // Same with rd=0: commit but no write
    drive(2'b10, 5'd0, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111);
    tick();
    in_valid = 1'b0;
    check_eq("rd0_wen", {31'd0, rf_wen}, 32'd0);
    check_eq("rd0_commit", {31'd0, commit_valid}, 32'd1);
    check_eq("rd0_pending", {31'd0, pending_valid}, 32'd0);
    tick();

    // CSR select with wen=0 on nonzero rd
    drive(2'b11, 5'd6, 1'b0, 32'h0000_2000, 32'h1111_1111);
    in_csr_rdata = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    check_eq("csr_wen", {31'd0, rf_wen}, 32'd0);
    check_eq("csr_data", rf_rd_data, 32'hCAFE_F00D);
    check_eq("csr_addr", {27'd0, rf_rd_addr}, 32'd6);
    check_eq("csr_commit", {31'd0, commit_valid}, 32'd1);
    tick();

    // Back-to-back ALU ops to rd 1, 2, 3
    drive(2'b00, 5'd1, 1'b1, 32'h0000_0100, 32'h0000_0011);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("b2b_wen", {31'd0, rf_wen}, 32'd1);
      check_eq("b2b_addr", {27'd0, rf_rd_addr}, i);
      check_eq("b2b_data", rf_rd_data, 32'h11 * i);
      check_eq("b2b_pending_rd", {27'd0, pending_rd}, i);
      in_rd_addr    = 5'(i + 1);
      in_alu_result = 32'h11 * (i + 1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("b2b_wen_off", {31'd0, rf_wen}, 32'd0);

    // Reset in WAIT_MEM
    drive(2'b01, 5'd7, 1'b1, 32'h0000_3000, 32'h0);
    in_load_funct3 = 3'b010;
    tick();
    in_valid = 1'b0;
    check_eq("rw_pending", {31'd0, pending_valid}, 32'd1);
    check_eq("rw_pending_rd", {27'd0, pending_rd}, 32'd7);
    tick();
    rst = 1'b1;
    #2;
    check_eq("rw_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rw_rst_mem_rready", {31'd0, mem_rready}, 32'd0);
    check_eq("rw_rst_pending", {31'd0, pending_valid}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check_eq("rw_no_wen", {31'd0, rf_wen}, 32'd0);
    check_eq("rw_no_commit", {31'd0, commit_valid}, 32'd0);
    check_eq("rw_no_pending", {31'd0, pending_valid}, 32'd0);
    drive(2'b00, 5'd4, 1'b1, 32'h0000_4000, 32'h0000_ABCD);
    tick();
    in_valid = 1'b0;
    check_eq("post_wen", {31'd0, rf_wen}, 32'd1);
    check_eq("post_addr", {27'd0, rf_rd_addr}, 32'd4);
    check_eq("post_data", rf_rd_data, 32'h0000_ABCD);
    check_eq("post_commit_pc", commit_pc, 32'h0000_4000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
